// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// the shift-counter width helper.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_CLR  = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

  // A counter needs at least one bit even when the modulus is 1 or 2.
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage

// File: rtl/shift_reg_univ_mod_counter.sv
// Modulo-MOD event counter with a registered one-cycle wrap pulse; clear takes
// priority over increment.
module mod_counter
  import shift_reg_pkg::*;
#(
  parameter int MOD = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clr,
  input  logic                      i_inc,
  output logic [cnt_width(MOD)-1:0] o_cnt,
  output logic                      o_wrap
);

  localparam int CW = cnt_width(MOD);
  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_wrap;

  // Count state and wrap pulse; wrap is low on every cycle that is not a wrapping increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= {CW{1'b0}};
      r_wrap <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= {CW{1'b0}};
      r_wrap <= 1'b0;
    end else if (i_inc) begin
      if (r_cnt == LAST) begin
        r_cnt  <= {CW{1'b0}};
        r_wrap <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_wrap <= 1'b0;
      end
    end else begin
      r_cnt  <= r_cnt;
      r_wrap <= 1'b0;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, load, logical shifts, rotates and clear, with
// a modulo-WIDTH counter flagging each completed full-word serial transfer.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] RSTVAL = {WIDTH{1'b0}}
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic [2:0]                  i_mode,
  input  logic [WIDTH-1:0]            i_d,
  input  logic                        i_si,
  output logic [WIDTH-1:0]            o_q,
  output logic                        o_so,
  output logic [cnt_width(WIDTH)-1:0] o_cnt,
  output logic                        o_done
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic             r_so;
  logic             w_inc;
  logic             w_clr;
  logic [CW-1:0]    w_cnt;
  logic             w_wrap;

  // Counter control: shifts and rotates count, load and clear restart the count.
  always_comb begin
    w_inc = 1'b0;
    w_clr = 1'b0;
    if (i_en) begin
      case (i_mode)
        MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: w_inc = 1'b1;
        MODE_LOAD, MODE_CLR:                    w_clr = 1'b1;
        default: begin
          w_inc = 1'b0;
          w_clr = 1'b0;
        end
      endcase
    end else begin
      w_inc = 1'b0;
      w_clr = 1'b0;
    end
  end

  // Data word and serial-out bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q  <= RSTVAL;
      r_so <= 1'b0;
    end else if (!i_en) begin
      r_q  <= r_q;
      r_so <= r_so;
    end else begin
      case (i_mode)
        MODE_LOAD: r_q <= i_d;
        MODE_SHL: begin
          r_q  <= {r_q[WIDTH-2:0], i_si};
          r_so <= r_q[WIDTH-1];
        end
        MODE_SHR: begin
          r_q  <= {i_si, r_q[WIDTH-1:1]};
          r_so <= r_q[0];
        end
        MODE_ROL: begin
          r_q  <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          r_so <= r_q[WIDTH-1];
        end
        MODE_ROR: begin
          r_q  <= {r_q[0], r_q[WIDTH-1:1]};
          r_so <= r_q[0];
        end
        MODE_CLR: begin
          r_q  <= RSTVAL;
          r_so <= 1'b0;
        end
        MODE_HOLD, MODE_RSVD: begin
          r_q  <= r_q;
          r_so <= r_so;
        end
        default: begin
          r_q  <= r_q;
          r_so <= r_so;
        end
      endcase
    end
  end

  mod_counter #(
    .MOD (WIDTH)
  ) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_cnt  (w_cnt),
    .o_wrap (w_wrap)
  );

  assign o_q    = r_q;
  assign o_so   = r_so;
  assign o_cnt  = w_cnt;
  assign o_done = w_wrap;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ (WIDTH=8, RSTVAL=8'hA5): the stimulus
// pushes hand-computed results, a monitor pops and compares after each edge.
module tb_shift_reg_univ;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
  localparam logic [2:0] ROL = 3'd4, ROR = 3'd5, CLR = 3'd6, RSVD = 3'd7;

  typedef struct {
    logic [7:0] q;
    logic       so;
    logic [2:0] cnt;
    logic       done;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;
  logic       si = 1'b0;
  logic [7:0] q;
  logic       so;
  logic [2:0] cnt;
  logic       done;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  shift_reg_univ #(
    .WIDTH  (8),
    .RSTVAL (8'hA5)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_mode (mode),
    .i_d    (d),
    .i_si   (si),
    .o_q    (q),
    .o_so   (so),
    .o_cnt  (cnt),
    .o_done (done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the result expected after the next edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m, input logic [7:0] dd,
                      input logic s, input logic [7:0] eq, input logic eso,
                      input logic [2:0] ecnt, input logic edone, input string nm);
    exp_t x;
    @(posedge clk);
    #2;
    rst = r; en = e; mode = m; d = dd; si = s;
    x.q = eq; x.so = eso; x.cnt = ecnt; x.done = edone; x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: compare each completed edge against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total++;
        if (q !== x.q) begin
          bad++;
          $display("FAIL %s q: got %h want %h", x.name, q, x.q);
        end
        total++;
        if (so !== x.so) begin
          bad++;
          $display("FAIL %s so: got %b want %b", x.name, so, x.so);
        end
        total++;
        if (cnt !== x.cnt) begin
          bad++;
          $display("FAIL %s cnt: got %0d want %0d", x.name, cnt, x.cnt);
        end
        total++;
        if (done !== x.done) begin
          bad++;
          $display("FAIL %s done: got %b want %b", x.name, done, x.done);
        end
      end
    end
  end

  initial begin
    logic [7:0] shl_q [8];
    logic       shl_so[8];
    shl_q  = '{8'h79, 8'hF3, 8'hE7, 8'hCF, 8'h9F, 8'h3F, 8'h7F, 8'hFF};
    shl_so = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 3'($urandom_range(7)), 8'($urandom), 1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, "reset");
    step(1'b0, 1'b1, HOLD, 8'h00, 1'b0, 8'hA5, 1'b0, 3'd0, 1'b0, "post_reset_hold");

    step(1'b0, 1'b1, LOAD, 8'h3C, 1'b0, 8'h3C, 1'b0, 3'd0, 1'b0, "load_3c");
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, SHL, 8'h00, 1'b1, shl_q[i], shl_so[i], 3'((i + 1) % 8), (i == 7), "shl_ser");
    step(1'b0, 1'b1, HOLD, 8'h00, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, "done_falls");

    step(1'b0, 1'b1, LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 3'd0, 1'b0, "load_81");
    step(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'hC0, 1'b1, 3'd1, 1'b0, "ror1");
    step(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'h60, 1'b0, 3'd2, 1'b0, "ror2");
    step(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'h30, 1'b0, 3'd3, 1'b0, "ror3");
    step(1'b0, 1'b1, ROL, 8'h00, 1'b0, 8'h60, 1'b0, 3'd4, 1'b0, "rol1");
    step(1'b0, 1'b1, ROL, 8'h00, 1'b0, 8'hC0, 1'b0, 3'd5, 1'b0, "rol2");
    step(1'b0, 1'b1, ROL, 8'h00, 1'b0, 8'h81, 1'b1, 3'd6, 1'b0, "rol3");

    step(1'b0, 1'b1, LOAD, 8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0, "load_01");
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h02, 1'b0, 3'd1, 1'b0, "stall_shl1");
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h04, 1'b0, 3'd2, 1'b0, "stall_shl2");
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h08, 1'b0, 3'd3, 1'b0, "stall_shl3");
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h10, 1'b0, 3'd4, 1'b0, "stall_shl4");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, SHL, 8'hFF, 1'b1, 8'h10, 1'b0, 3'd4, 1'b0, "en_low");
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h20, 1'b0, 3'd5, 1'b0, "resume_shl5");
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h40, 1'b0, 3'd6, 1'b0, "resume_shl6");
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h80, 1'b0, 3'd7, 1'b0, "resume_shl7");
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, "resume_shl8");
    step(1'b0, 1'b0, LOAD, 8'hEE, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, "en_low_done");

    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h00, 1'b0, 3'(i + 1), 1'b0, "shr_pre_wrap");
    step(1'b0, 1'b1, LOAD, 8'h55, 1'b0, 8'h55, 1'b0, 3'd0, 1'b0, "load_beats_wrap");
    step(1'b0, 1'b1, SHR, 8'h00, 1'b1, 8'hAA, 1'b1, 3'd1, 1'b0, "shr_55");
    step(1'b1, 1'b1, SHR, 8'h00, 1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, "rst_beats_shr");

    step(1'b0, 1'b1, LOAD, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "load_00");
    step(1'b0, 1'b1, SHR, 8'h00, 1'b1, 8'h80, 1'b0, 3'd1, 1'b0, "shr_si1_a");
    step(1'b0, 1'b1, SHR, 8'h00, 1'b1, 8'hC0, 1'b0, 3'd2, 1'b0, "shr_si1_b");
    step(1'b0, 1'b1, RSVD, 8'h12, 1'b1, 8'hC0, 1'b0, 3'd2, 1'b0, "reserved_hold");
    step(1'b0, 1'b1, ROL, 8'h00, 1'b0, 8'h81, 1'b1, 3'd3, 1'b0, "rol_c0");
    step(1'b0, 1'b1, HOLD, 8'h34, 1'b0, 8'h81, 1'b1, 3'd3, 1'b0, "hold_keeps_so");
    step(1'b0, 1'b1, CLR, 8'h00, 1'b0, 8'hA5, 1'b0, 3'd0, 1'b0, "clr");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
